alu_seq_ctrl: RTL and testbench

//   Issuing side of the ALU port: accepts one ALU request per valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM state type and helpers shared by the ALU sequencer
package alu_seq_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [3:0] ADD_OP = 4'd0;
    localparam logic [3:0] SUB_OP = 4'd1;
    localparam logic [3:0] AND_OP = 4'd2;
    localparam logic [3:0] OR_OP  = 4'd3;
    localparam logic [3:0] XOR_OP = 4'd4;
    localparam logic [3:0] NOT_OP = 4'd5;
    localparam logic [3:0] SLA_OP = 4'd6;
    localparam logic [3:0] SRA_OP = 4'd7;
    localparam logic [3:0] SRL_OP = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == SLA_OP) || (op == SRA_OP) || (op == SRL_OP);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - request/response sequencer driving an external single-bit-shift ALU (optional ALU_SEQ_PERF_EN counters)
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = alu_seq_pkg::SHAMT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_shift,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_zero,
    output logic              rsp_carry
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_ops,
    output logic [15:0]       perf_busy
`endif
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                shift_q, shift_d;
    // SRA ignores the ALU shift input, so a zero-count SRA must not touch the ALU at all
    logic                bypass_q, bypass_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;

    // State and datapath registers; reset discards any in-flight op or pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            shift_q  <= 1'b0;
            bypass_q <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bypass_q <= bypass_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state, pass sequencing and ALU drive; ALU inputs idle at zero outside EXEC
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bypass_d  = bypass_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        alu_shift = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d     = req_op;
                    acc_d    = req_a;
                    b_d      = req_b;
                    shift_d  = is_shift(req_op) && (req_shamt != '0);
                    bypass_d = (req_op == SRA_OP) && (req_shamt == '0);
                    cnt_d    = (is_shift(req_op) && (req_shamt != '0)) ? req_shamt : CNT_ONE;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (!bypass_q) begin
                    alu_a     = acc_q;
                    alu_b     = b_q;
                    alu_op    = op_q;
                    alu_shift = shift_q;
                    acc_d     = alu_res;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (bypass_q) begin
                        res_d   = acc_q;
                        zero_d  = (acc_q == '0);
                        carry_d = 1'b0;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = alu_zero;
                        carry_d = alu_carry;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_res   = res_q;
    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] ops_q;
    logic [15:0] busy_q;

    // Saturating activity counters: completed responses and cycles spent issuing ALU passes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q  <= '0;
            busy_q <= '0;
        end else begin
            if ((state_q == RESP) && rsp_ready && (ops_q != 16'hFFFF)) begin
                ops_q <= ops_q + 16'd1;
            end
            if ((state_q == EXEC) && (busy_q != 16'hFFFF)) begin
                busy_q <= busy_q + 16'd1;
            end
        end
    end

    assign perf_ops  = ops_q;
    assign perf_busy = busy_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed vector bench for alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_shift;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_carry;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_busy;
`endif

    int n_tests;
    int n_fail;

    alu_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_shift (alu_shift),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural team ALU: one-bit shifts, SRA ignores shiftAmount, carry only on ADD
    always_comb begin
        logic [32:0] sum;
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = 1'b0;
        case (alu_op)
            4'd0: begin alu_res = sum[31:0]; alu_carry = sum[32]; end
            4'd1: alu_res = alu_a - alu_b;
            4'd2: alu_res = alu_a & alu_b;
            4'd3: alu_res = alu_a | alu_b;
            4'd4: alu_res = alu_a ^ alu_b;
            4'd5: alu_res = ~alu_a;
            4'd6: alu_res = alu_shift ? {alu_a[30:0], 1'b0} : alu_a;
            4'd7: alu_res = {alu_a[31], alu_a[31:1]};
            4'd8: alu_res = alu_shift ? {1'b0, alu_a[31:1]} : alu_a;
            default: alu_res = 32'h0;
        endcase
        alu_zero = (alu_res == 32'h0);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        c;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the response, leave rsp_ready low
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_shamt = sh;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", {31'b0, rsp_valid}, 32'h1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] ops_before;
        n_tests   = 0;
        n_fail    = 0;
        ops_before = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;

        vecs[0]  = '{ADD_OP, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b1, 1};
        vecs[1]  = '{ADD_OP, 32'h5, 32'h7, 5'd0, 32'hC, 1'b0, 1'b0, 1};
        vecs[2]  = '{SUB_OP, 32'h9, 32'h4, 5'd3, 32'h5, 1'b0, 1'b0, 1};
        vecs[3]  = '{AND_OP, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F, 1'b0, 1'b0, 1};
        vecs[4]  = '{OR_OP, 32'h0000_F000, 32'h0000_0F00, 5'd0, 32'h0000_FF00, 1'b0, 1'b0, 1};
        vecs[5]  = '{XOR_OP, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd0, 32'h0, 1'b1, 1'b0, 1};
        vecs[6]  = '{NOT_OP, 32'h0, 32'h1234, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[7]  = '{SRA_OP, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 4};
        vecs[8]  = '{SRA_OP, 32'h8000_0000, 32'h0, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1};
        vecs[9]  = '{SRL_OP, 32'h8000_0000, 32'h0, 5'd31, 32'h1, 1'b0, 1'b0, 31};
        vecs[10] = '{SLA_OP, 32'h1, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 31};
        vecs[11] = '{SLA_OP, 32'h1234, 32'h0, 5'd0, 32'h1234, 1'b0, 1'b0, 1};
        vecs[12] = '{SRL_OP, 32'h1, 32'h0, 5'd1, 32'h0, 1'b1, 1'b0, 1};
        vecs[13] = '{4'hF, 32'h7, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1};
        vecs[14] = '{SRA_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1};
        vecs[15] = '{SLA_OP, 32'h8000_0001, 32'h0, 5'd1, 32'h2, 1'b0, 1'b0, 1};
        vecs[16] = '{SRL_OP, 32'hFFFF_FFFF, 32'h0, 5'd16, 32'h0000_FFFF, 1'b0, 1'b0, 16};

        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rsp_res", rsp_res, 32'h0);
        chk("reset_flags", {30'b0, rsp_zero, rsp_carry}, 32'h0);
        chk("reset_alu_drive", alu_a | alu_b | {27'b0, alu_op, alu_shift}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, lat);
            chk($sformatf("v%0d_res", i), rsp_res, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {31'b0, rsp_zero}, {31'b0, vecs[i].z});
            chk($sformatf("v%0d_carry", i), {31'b0, rsp_carry}, {31'b0, vecs[i].c});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
`ifdef ALU_SEQ_PERF_EN
            ops_before = perf_ops;
            consume();
            chk($sformatf("v%0d_perf_ops", i), {16'b0, perf_ops}, {16'b0, ops_before + 16'd1});
`else
            consume();
`endif
        end

        // Held response: SUB 5-5 with the consumer stalled for six cycles
        issue(SUB_OP, 32'h5, 32'h5, 5'd0, lat);
        chk("hold_latency", lat, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("hold_rsp_res", rsp_res, 32'h0);
            chk("hold_rsp_zero", {31'b0, rsp_zero}, 32'h1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'h0);
        end
        consume();
        @(negedge clk);
        chk("hold_back_idle", {30'b0, req_ready, rsp_valid}, 32'h2);

        // Reset during pass 3 of an SRL by 10
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SRL_OP;
        req_a     = 32'hFFFF_0000;
        req_b     = 32'h0;
        req_shamt = 5'd10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("srl_pass1_alu_a", alu_a, 32'hFFFF_0000);
        chk("srl_pass1_ctl", {27'b0, alu_op, alu_shift}, {27'b0, SRL_OP, 1'b1});
        chk("srl_busy_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("srl_pass3_alu_a", alu_a, 32'h3FFF_C000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("mid_rst_rsp", rsp_res | {30'b0, rsp_zero, rsp_carry}, 32'h0);
        chk("mid_rst_alu", alu_a | alu_b | {27'b0, alu_op, alu_shift}, 32'h0);
`ifdef ALU_SEQ_PERF_EN
        chk("mid_rst_perf", {perf_ops, perf_busy}, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        chk("post_rst_no_rsp", lat, 0);
        issue(ADD_OP, 32'h3, 32'h4, 5'd0, lat);
        chk("post_rst_res", rsp_res, 32'h7);
        chk("post_rst_latency", lat, 1);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
